// File: rtl/hc165_reader.sv
// Scan controller for a 74HC165 PISO chain: drives PL/CP, samples Q7 MSB-first, publishes the word.
// Optional build macro DEBOUNCE_EN: publish only after two identical consecutive scans.
module hc165_reader #(
    parameter int WIDTH    = 16,
    parameter int CLK_DIV  = 25,
    parameter int SCAN_GAP = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in165,
    output logic             load165,
    output logic             clk165,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(SCAN_GAP) + 1;
    localparam int KW = $clog2(WIDTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [KW-1:0]    k_q, k_d;
    logic             high_q, high_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             load_q, load_d;
    logic             clk_q, clk_d;
    logic             busy_q, busy_d;
`ifdef DEBOUNCE_EN
    logic [WIDTH-1:0] prev_q, prev_d;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        k_d     = k_q;
        high_d  = high_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef DEBOUNCE_EN
        prev_d  = prev_q;
`endif
        case (state_q)
            IDLE: begin
                // Gap counter saturates so a late en starts the scan on its first high cycle.
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 1'b1;
                end else if (en) begin
                    state_d = LOAD;
                    div_d   = '0;
                end
            end
            LOAD: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    k_d     = '0;
                    high_d  = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!high_q) begin
                        shreg_d = {shreg_q[WIDTH-2:0], in165};
                        if (k_q == K_LAST) state_d = DONE;
                        else               high_d  = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        k_d    = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gap_d   = '0;
`ifdef DEBOUNCE_EN
                prev_d = shreg_q;
                if (shreg_q == prev_q && shreg_q != data_q) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end
`else
                data_d  = shreg_q;
                valid_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
        // Pin outputs are decoded from next state so the registered pins line up with the FSM.
        load_d = (state_d != LOAD);
        clk_d  = (state_d == SHIFT) && high_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            k_q     <= '0;
            high_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            load_q  <= 1'b1;
            clk_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_EN
            prev_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            k_q     <= k_d;
            high_q  <= high_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            load_q  <= load_d;
            clk_q   <= clk_d;
            busy_q  <= busy_d;
`ifdef DEBOUNCE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign load165 = load_q;
    assign clk165  = clk_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
endmodule
